// File: rtl/uart_pkg.sv
// UART constants and helpers shared by the transmit and receive datapaths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bits on the line per frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int data_bits, input int parity_en,
                                   input int stop_bits);
    return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Parity over up to 9 data bits; callers zero-extend narrower words,
  // which leaves the XOR unchanged. odd=1 inverts to give odd parity.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Counts shifted-out bits of a frame and flags when the whole frame has gone.
// Latency: count updates one clk after inc/clear; terminal is decoded from the register.
// Backpressure: none; holds at FRAME_LEN (never wraps) until cleared.
module tx_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int CW        = $clog2(FRAME_LEN + 1);

  logic [CW-1:0] bit_cnt;

  assign terminal = (bit_cnt == CW'(FRAME_LEN));

  // Clear has priority; increments stop at the terminal value so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bit_cnt <= '0;
    end else if (inc && !terminal) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tx_frame_shifter.sv
// UART transmit frame builder and serializer driven by controller load/shift pulses.
// Latency: tx changes one clk after each shift; count_done is combinational in the final shift cycle.
// Backpressure: load ignored while busy; shift ignored while idle.
module tx_frame_shifter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 count_done,
  output logic                 busy
);

  localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("tx_frame_shifter: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("tx_frame_shifter: STOP_BITS must be 1 or 2");
  end

  logic [FRAME_LEN-1:0] sreg;
  logic [FRAME_LEN-1:0] load_frame;
  logic                 load_ok;
  logic                 shift_ok;
  logic                 cnt_terminal;

  assign load_ok  = load & ~busy;
  assign shift_ok = shift & busy;

  // The (FRAME_LEN+1)th shift closes the last stop bit; held low during reset.
  assign count_done = shift_ok & cnt_terminal & ~reset;

  // Frame image, LSB goes out first: start, data LSB-first, parity, stop ones.
  always_comb begin
    load_frame                = '1;
    load_frame[0]             = START_LEVEL;
    load_frame[DATA_BITS:1]   = data_in;
    if (PARITY_EN != 0) begin
      load_frame[DATA_BITS+1] = parity_bit(9'(data_in), (PARITY_ODD != 0));
    end
  end

  // Shift register, line driver and busy flag; load beats a simultaneous shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= IDLE_LEVEL;
      busy <= 1'b0;
      sreg <= '1;
    end else if (load_ok) begin
      sreg <= load_frame;
      busy <= 1'b1;
    end else if (count_done) begin
      tx   <= IDLE_LEVEL;
      busy <= 1'b0;
      sreg <= '1;
    end else if (shift_ok) begin
      tx   <= sreg[0];
      sreg <= {1'b1, sreg[FRAME_LEN-1:1]};
    end
  end

  tx_bit_counter #(
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (PARITY_EN),
    .STOP_BITS (STOP_BITS)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_ok | count_done),
    .inc      (shift_ok & ~count_done),
    .terminal (cnt_terminal)
  );

endmodule

// File: tb/tb_tx_frame_shifter.sv
// Self-checking bench for tx_frame_shifter in 8N1, 8E1, 8O1 and 7N2 builds.
// Latency: expected line bits are queued at load and compared after each shift.
// Backpressure: exercises ignored loads while busy and ignored shifts while idle.
module tb_tx_frame_shifter;

  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_v  [4];
  logic       shift_v [4];
  logic [8:0] din     [4];
  logic       tx_v    [4];
  logic       cd_v    [4];
  logic       busy_v  [4];

  int db [4] = '{8, 8, 8, 7};
  int pe [4] = '{0, 1, 1, 0};
  int po [4] = '{0, 0, 1, 0};
  int sb [4] = '{1, 1, 1, 2};

  logic exp_q [$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tx_frame_shifter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .reset(reset), .load(load_v[0]), .shift(shift_v[0]), .data_in(din[0][7:0]),
    .tx(tx_v[0]), .count_done(cd_v[0]), .busy(busy_v[0]));
  tx_frame_shifter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .reset(reset), .load(load_v[1]), .shift(shift_v[1]), .data_in(din[1][7:0]),
    .tx(tx_v[1]), .count_done(cd_v[1]), .busy(busy_v[1]));
  tx_frame_shifter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
    .clk(clk), .reset(reset), .load(load_v[2]), .shift(shift_v[2]), .data_in(din[2][7:0]),
    .tx(tx_v[2]), .count_done(cd_v[2]), .busy(busy_v[2]));
  tx_frame_shifter #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_7n2 (
    .clk(clk), .reset(reset), .load(load_v[3]), .shift(shift_v[3]), .data_in(din[3][6:0]),
    .tx(tx_v[3]), .count_done(cd_v[3]), .busy(busy_v[3]));

  // Scoreboard: push the line bits expected after shifts 1..FRAME_LEN.
  task automatic push_frame(input int c, input logic [8:0] d);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db[c]; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe[c] != 0) exp_q.push_back(p ^ (po[c] != 0));
    for (int i = 0; i < sb[c]; i++) exp_q.push_back(1'b1);
  endtask

  // Load pulse (optionally with a shift); reports count_done before and tx/busy after the edge.
  task automatic do_load(input int c, input logic [8:0] d, input logic with_shift,
                         output logic cdv, output logic txv, output logic bv);
    @(negedge clk);
    load_v[c]  = 1'b1;
    shift_v[c] = with_shift;
    din[c]     = d;
    #1 cdv = cd_v[c];
    @(posedge clk);
    #1;
    load_v[c]  = 1'b0;
    shift_v[c] = 1'b0;
    din[c]     = ~d;
    txv = tx_v[c];
    bv  = busy_v[c];
  endtask

  // One shift pulse after a baud-like gap.
  task automatic one_shift(input int c, output logic cdv, output logic txv, output logic bv);
    repeat (GAP - 1) @(posedge clk);
    @(negedge clk);
    shift_v[c] = 1'b1;
    #1 cdv = cd_v[c];
    @(posedge clk);
    #1;
    shift_v[c] = 1'b0;
    txv = tx_v[c];
    bv  = busy_v[c];
  endtask

  task automatic check_bits(input int c, input string name, input int n);
    logic cdv, txv, bv, e;
    for (int k = 0; k < n; k++) begin
      one_shift(c, cdv, txv, bv);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s shift%0d: scoreboard empty, tx=%b", name, k, txv);
      end else begin
        e = exp_q.pop_front();
        if (txv !== e || cdv !== 1'b0 || bv !== 1'b1) begin
          errors++;
          $display("FAIL %s shift%0d: tx=%b cd=%b busy=%b, want tx=%b cd=0 busy=1",
                   name, k, txv, cdv, bv, e);
        end
      end
    end
  endtask

  task automatic check_done(input int c, input string name);
    logic cdv, txv, bv;
    one_shift(c, cdv, txv, bv);
    checks++;
    if (cdv !== 1'b1 || txv !== 1'b1 || bv !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s done: cd=%b tx=%b busy=%b left=%0d, want cd=1 tx=1 busy=0 left=0",
               name, cdv, txv, bv, exp_q.size());
    end
  endtask

  task automatic start_frame(input int c, input string name, input logic [8:0] d);
    logic cdv, txv, bv;
    push_frame(c, d);
    do_load(c, d, 1'b0, cdv, txv, bv);
    checks++;
    if (txv !== 1'b1 || bv !== 1'b1 || cdv !== 1'b0) begin
      errors++;
      $display("FAIL %s load: tx=%b busy=%b cd=%b, want tx=1 busy=1 cd=0", name, txv, bv, cdv);
    end
  endtask

  task automatic run_frame(input int c, input string name, input logic [8:0] d);
    start_frame(c, name, d);
    check_bits(c, name, exp_q.size());
    check_done(c, name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      load_v[c] = 1'b0; shift_v[c] = 1'b1; din[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tx_v[c] !== 1'b1 || busy_v[c] !== 1'b0 || cd_v[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: tx=%b busy=%b cd=%b, want 1 0 0", c, tx_v[c], busy_v[c], cd_v[c]);
      end
      shift_v[c] = 1'b0;
    end
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_8n1();
    run_frame(0, "8n1_a5", 9'h0A5);
  endtask

  task automatic test_parity();
    run_frame(1, "8e1_a5", 9'h0A5);
    run_frame(2, "8o1_a5", 9'h0A5);
    run_frame(2, "8o1_07", 9'h007);
  endtask

  task automatic test_7n2();
    run_frame(3, "7n2_41", 9'h041);
  endtask

  task automatic test_load_while_busy();
    logic cdv, txv, bv;
    start_frame(0, "busy_load", 9'h0A5);
    check_bits(0, "busy_load", 3);
    one_shift(0, cdv, txv, bv);
    checks++;
    if (txv !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL busy_load shift4: tx=%b", txv);
    end
    do_load(0, 9'h0FF, 1'b0, cdv, txv, bv);
    checks++;
    if (bv !== 1'b1 || cdv !== 1'b0) begin
      errors++;
      $display("FAIL busy_load ignored: busy=%b cd=%b, want busy=1 cd=0", bv, cdv);
    end
    check_bits(0, "busy_load", exp_q.size());
    check_done(0, "busy_load");
  endtask

  task automatic test_shift_idle();
    logic cdv, txv, bv;
    for (int c = 0; c < 4; c++) begin
      one_shift(c, cdv, txv, bv);
      checks++;
      if (cdv !== 1'b0 || txv !== 1'b1 || bv !== 1'b0) begin
        errors++;
        $display("FAIL idle_shift dut%0d: cd=%b tx=%b busy=%b, want 0 1 0", c, cdv, txv, bv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic cdv, txv, bv;
    push_frame(0, 9'h03C);
    do_load(0, 9'h03C, 1'b1, cdv, txv, bv);
    checks++;
    if (txv !== 1'b1 || bv !== 1'b1 || cdv !== 1'b0) begin
      errors++;
      $display("FAIL load_shift: tx=%b busy=%b cd=%b, want tx=1 busy=1 cd=0", txv, bv, cdv);
    end
    check_bits(0, "load_shift", exp_q.size());
    check_done(0, "load_shift");
    // Load in the cycle right after count_done.
    start_frame(0, "b2b", 9'h096);
    check_bits(0, "b2b", exp_q.size());
    check_done(0, "b2b");
  endtask

  task automatic test_reset_midframe();
    start_frame(0, "rst_mid", 9'h0A5);
    check_bits(0, "rst_mid", 4);
    repeat (GAP - 1) @(posedge clk);
    @(negedge clk);
    shift_v[0] = 1'b1;
    reset      = 1'b1;
    #1;
    checks++;
    if (cd_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid cd: cd=%b, want 0", cd_v[0]);
    end
    @(posedge clk);
    #1;
    shift_v[0] = 1'b0;
    reset      = 1'b0;
    checks++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cd_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid state: tx=%b busy=%b cd=%b, want 1 0 0", tx_v[0], busy_v[0], cd_v[0]);
    end
    exp_q.delete();
    run_frame(0, "after_rst", 9'h05A);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_load_while_busy();
    test_shift_idle();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
